// File: rtl/pong_vga_pkg.sv
// Shared 640x480 VGA timing constants and receive-monitor types for the Pong display path.
package pong_vga_pkg;

    localparam int H_ACTIVE = 640;
    localparam int H_SYNC   = 96;
    localparam int H_BP     = 48;
    localparam int H_TOTAL  = 800;
    localparam int V_ACTIVE = 480;
    localparam int V_SYNC   = 2;
    localparam int V_BP     = 33;
    localparam int V_TOTAL  = 525;

    localparam logic SYNC_POL    = 1'b0;
    localparam int   LOCK_FRAMES = 2;

    localparam int               CNT_W   = 10;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {
        ST_SEARCH,
        ST_ACQUIRE,
        ST_LOCKED
    } mon_state_t;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] value);
        return (value == CNT_MAX) ? value : value + CNT_W'(1);
    endfunction

endpackage

// File: rtl/vga_sync_edge.sv
// Previous-level register for one sync line; pulses on the tick where the sync becomes active.
module vga_sync_edge #(
    parameter logic POL = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic pix_en,
    input  logic sync,
    output logic edge_pulse
);

    logic now_active;
    logic prev_active;

    assign now_active = (sync == POL);

    // NOTE: the register stores "was active", so clearing it in reset means the previous level is inactive.
    always_ff @(posedge clk) begin
        if (reset) begin
            prev_active <= 1'b0;
        end else if (pix_en) begin
            prev_active <= now_active;
        end
    end

    assign edge_pulse = pix_en && now_active && !prev_active;

endmodule

// File: rtl/vga_rx_monitor.sv
// Receive-side VGA monitor: recovers pixel coordinates, checks line/frame timing, locks and checksums frames.
module vga_rx_monitor #(
    parameter int   H_ACTIVE    = pong_vga_pkg::H_ACTIVE,
    parameter int   H_SYNC      = pong_vga_pkg::H_SYNC,
    parameter int   H_BP        = pong_vga_pkg::H_BP,
    parameter int   H_TOTAL     = pong_vga_pkg::H_TOTAL,
    parameter int   V_ACTIVE    = pong_vga_pkg::V_ACTIVE,
    parameter int   V_SYNC      = pong_vga_pkg::V_SYNC,
    parameter int   V_BP        = pong_vga_pkg::V_BP,
    parameter int   V_TOTAL     = pong_vga_pkg::V_TOTAL,
    parameter logic SYNC_POL    = pong_vga_pkg::SYNC_POL,
    parameter int   LOCK_FRAMES = pong_vga_pkg::LOCK_FRAMES
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        pix_en,
    input  logic        hsync,
    input  logic        vsync,
    input  logic [11:0] rgb,
    output logic        rx_valid,
    output logic [9:0]  rx_x,
    output logic [9:0]  rx_y,
    output logic [11:0] rx_rgb,
    output logic        locked,
    output logic        frame_done,
    output logic [15:0] frame_sum,
    output logic        err,
    output logic [7:0]  err_count
);

    import pong_vga_pkg::*;

    localparam logic [CNT_W-1:0] H_FIRST    = CNT_W'(H_SYNC + H_BP);
    localparam logic [CNT_W-1:0] H_LAST     = CNT_W'(H_SYNC + H_BP + H_ACTIVE - 1);
    localparam logic [CNT_W-1:0] V_FIRST    = CNT_W'(V_SYNC + V_BP);
    localparam logic [CNT_W-1:0] V_LAST     = CNT_W'(V_SYNC + V_BP + V_ACTIVE - 1);
    localparam logic [CNT_W-1:0] H_NEAR_MAX = CNT_MAX - CNT_W'(1);
    localparam logic [CNT_W:0]   H_TOT      = (CNT_W + 1)'(H_TOTAL);
    localparam logic [CNT_W:0]   V_TOT      = (CNT_W + 1)'(V_TOTAL);
    localparam logic [7:0]       LOCK_N     = 8'(LOCK_FRAMES);

    mon_state_t       state;
    logic [CNT_W-1:0] h_cnt;
    logic [CNT_W-1:0] v_cnt;
    logic [15:0]      acc;
    logic [7:0]       good_cnt;
    logic             frame_bad;
    logic             first_hs;
    logic             hs_edge;
    logic             vs_edge;

    vga_sync_edge #(.POL(SYNC_POL)) u_hs_edge (
        .clk        (clk),
        .reset      (reset),
        .pix_en     (pix_en),
        .sync       (hsync),
        .edge_pulse (hs_edge)
    );

    vga_sync_edge #(.POL(SYNC_POL)) u_vs_edge (
        .clk        (clk),
        .reset      (reset),
        .pix_en     (pix_en),
        .sync       (vsync),
        .edge_pulse (vs_edge)
    );

    logic [CNT_W-1:0] h_next;
    logic [CNT_W-1:0] v_next;
    logic [CNT_W:0]   line_len;
    logic [CNT_W:0]   frame_len;
    logic             active;
    logic             line_bad;
    logic             frame_good;

    // NOTE: every always_comb output gets a value on every path, so no latch can be inferred.
    always_comb begin
        h_next    = hs_edge ? '0 : sat_inc(h_cnt);
        v_next    = vs_edge ? '0 : (hs_edge ? sat_inc(v_cnt) : v_cnt);
        line_len  = {1'b0, h_cnt} + (CNT_W + 1)'(1);
        frame_len = {1'b0, v_cnt} + {{CNT_W{1'b0}}, hs_edge};
        active    = (h_next >= H_FIRST) && (h_next <= H_LAST) &&
                    (v_next >= V_FIRST) && (v_next <= V_LAST);
        // The first line after leaving SEARCH was timed from an arbitrary point, so it is not judged.
        line_bad  = (state != ST_SEARCH) &&
                    ((hs_edge && !first_hs && (line_len != H_TOT)) ||
                     (pix_en && !hs_edge && (h_cnt == H_NEAR_MAX)));
        frame_good = !frame_bad && !line_bad && (frame_len == V_TOT);
    end

    assign locked = (state == ST_LOCKED);

    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_SEARCH;
            h_cnt      <= '0;
            v_cnt      <= '0;
            acc        <= '0;
            good_cnt   <= '0;
            frame_bad  <= 1'b0;
            first_hs   <= 1'b1;
            rx_valid   <= 1'b0;
            rx_x       <= '0;
            rx_y       <= '0;
            rx_rgb     <= '0;
            frame_done <= 1'b0;
            frame_sum  <= '0;
            err        <= 1'b0;
            err_count  <= '0;
        end else begin
            rx_valid   <= 1'b0;
            frame_done <= 1'b0;
            err        <= 1'b0;
            if (pix_en) begin
                h_cnt     <= h_next;
                v_cnt     <= v_next;
                acc       <= vs_edge ? 16'd0 : (active ? acc + {4'b0, rgb} : acc);
                frame_bad <= vs_edge ? 1'b0 : (frame_bad || line_bad);
                if (hs_edge) begin
                    first_hs <= 1'b0;
                end
                if ((state == ST_LOCKED) && active) begin
                    rx_valid <= 1'b1;
                    rx_x     <= h_next - H_FIRST;
                    rx_y     <= v_next - V_FIRST;
                    rx_rgb   <= rgb;
                end
                case (state)
                    ST_SEARCH: begin
                        first_hs <= 1'b1;
                        if (vs_edge) begin
                            state    <= ST_ACQUIRE;
                            good_cnt <= '0;
                        end
                    end
                    ST_ACQUIRE: begin
                        if (vs_edge) begin
                            if (frame_good) begin
                                good_cnt <= good_cnt + 8'd1;
                                if (good_cnt + 8'd1 >= LOCK_N) begin
                                    state      <= ST_LOCKED;
                                    frame_done <= 1'b1;
                                    frame_sum  <= acc;
                                end
                            end else begin
                                good_cnt <= '0;
                            end
                        end
                    end
                    ST_LOCKED: begin
                        if (line_bad || (vs_edge && !frame_good)) begin
                            state <= ST_SEARCH;
                            err   <= 1'b1;
                            if (err_count != 8'hFF) begin
                                err_count <= err_count + 8'd1;
                            end
                        end else if (vs_edge) begin
                            frame_done <= 1'b1;
                            frame_sum  <= acc;
                        end
                    end
                    default: state <= ST_SEARCH;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_vga_rx_monitor.sv
// Self-checking bench for vga_rx_monitor using a reduced raster so whole frames fit in a short run.
`timescale 1ns/1ps
module tb_vga_rx_monitor;

    localparam int H_ACTIVE = 8;
    localparam int H_SYNC   = 2;
    localparam int H_BP     = 2;
    localparam int H_TOTAL  = 14;
    localparam int V_ACTIVE = 4;
    localparam int V_SYNC   = 1;
    localparam int V_BP     = 2;
    localparam int V_TOTAL  = 9;
    localparam int H_FIRST  = H_SYNC + H_BP;
    localparam int V_FIRST  = V_SYNC + V_BP;
    localparam int SUM_ONE  = H_ACTIVE * V_ACTIVE;
    localparam int SUM_X    = V_ACTIVE * (H_ACTIVE * (H_ACTIVE - 1) / 2);

    logic        clk = 1'b0;
    logic        reset;
    logic        pix_en;
    logic        hsync;
    logic        vsync;
    logic [11:0] rgb;
    logic        rx_valid;
    logic [9:0]  rx_x;
    logic [9:0]  rx_y;
    logic [11:0] rx_rgb;
    logic        locked;
    logic        frame_done;
    logic [15:0] frame_sum;
    logic        err;
    logic [7:0]  err_count;

    always #5 clk = ~clk;

    vga_rx_monitor #(
        .H_ACTIVE(H_ACTIVE), .H_SYNC(H_SYNC), .H_BP(H_BP), .H_TOTAL(H_TOTAL),
        .V_ACTIVE(V_ACTIVE), .V_SYNC(V_SYNC), .V_BP(V_BP), .V_TOTAL(V_TOTAL),
        .SYNC_POL(1'b0), .LOCK_FRAMES(2)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .pix_en     (pix_en),
        .hsync      (hsync),
        .vsync      (vsync),
        .rgb        (rgb),
        .rx_valid   (rx_valid),
        .rx_x       (rx_x),
        .rx_y       (rx_y),
        .rx_rgb     (rx_rgb),
        .locked     (locked),
        .frame_done (frame_done),
        .frame_sum  (frame_sum),
        .err        (err),
        .err_count  (err_count)
    );

    typedef struct packed {
        logic [9:0]  x;
        logic [9:0]  y;
        logic [11:0] c;
    } pix_t;

    typedef struct {
        int lines;
        int bad_line;
        bit xpat;
        bit lk_during;
        bit exp_locked;
        int exp_errc;
        int exp_err;
        int exp_fd;
        int exp_sum;
        int exp_rxv;
    } vec_t;

    pix_t        sb[$];
    pix_t        mon_exp;
    int          n_cmp   = 0;
    int          n_bad   = 0;
    int          n_rxv   = 0;
    int          n_fd    = 0;
    int          n_err   = 0;
    int          err_at  = 0;
    int          tick_no = 0;
    logic [15:0] last_sum = '0;
    bit          exp_lk  = 1'b0;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rx_valid) begin
            n_rxv++;
            if (sb.size() == 0) begin
                check("rx_valid_unexpected", int'(rx_valid), 0);
            end else begin
                mon_exp = sb.pop_front();
                check("rx_x", int'(rx_x), int'(mon_exp.x));
                check("rx_y", int'(rx_y), int'(mon_exp.y));
                check("rx_rgb", int'(rx_rgb), int'(mon_exp.c));
            end
        end
        if (frame_done) begin
            n_fd++;
            last_sum = frame_sum;
        end
        if (err) begin
            n_err++;
            err_at = tick_no;
        end
    end

    task automatic tick(input logic hs, input logic vs, input logic [11:0] c);
        @(negedge clk);
        tick_no++;
        hsync  = hs;
        vsync  = vs;
        rgb    = c;
        pix_en = 1'b1;
        @(negedge clk);
        pix_en = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic send_frame(input int lines, input int bad_line, input bit xpat, input bit lk);
        int          len;
        bit          act;
        logic [11:0] c;
        pix_t        p;
        exp_lk = lk;
        for (int v = 0; v < lines; v++) begin
            if (bad_line >= 0 && v == bad_line + 1) exp_lk = 1'b0;
            len = (v == bad_line) ? H_TOTAL + 1 : H_TOTAL;
            for (int h = 0; h < len; h++) begin
                act = (h >= H_FIRST) && (h < H_FIRST + H_ACTIVE) &&
                      (v >= V_FIRST) && (v < V_FIRST + V_ACTIVE);
                c = !act ? 12'hFFF : (xpat ? 12'(h - H_FIRST) : 12'h001);
                if (act && exp_lk) begin
                    p.x = 10'(h - H_FIRST);
                    p.y = 10'(v - V_FIRST);
                    p.c = c;
                    sb.push_back(p);
                end
                tick(h >= H_SYNC, v >= V_SYNC, c);
            end
        end
    endtask

    task automatic apply_row(input int id, input vec_t r);
        int rxv0;
        int fd0;
        int err0;
        rxv0 = n_rxv;
        fd0  = n_fd;
        err0 = n_err;
        send_frame(r.lines, r.bad_line, r.xpat, r.lk_during);
        check($sformatf("v%0d_locked", id), int'(locked), int'(r.exp_locked));
        check($sformatf("v%0d_err_count", id), int'(err_count), r.exp_errc);
        check($sformatf("v%0d_err_pulses", id), n_err - err0, r.exp_err);
        check($sformatf("v%0d_frame_done", id), n_fd - fd0, r.exp_fd);
        check($sformatf("v%0d_rx_valid_count", id), n_rxv - rxv0, r.exp_rxv);
        if (r.exp_fd > 0) check($sformatf("v%0d_frame_sum", id), int'(last_sum), r.exp_sum);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_rx_valid"}, int'(rx_valid), 0);
        check({tag, "_rx_x"}, int'(rx_x), 0);
        check({tag, "_rx_y"}, int'(rx_y), 0);
        check({tag, "_rx_rgb"}, int'(rx_rgb), 0);
        check({tag, "_locked"}, int'(locked), 0);
        check({tag, "_frame_done"}, int'(frame_done), 0);
        check({tag, "_frame_sum"}, int'(frame_sum), 0);
        check({tag, "_err"}, int'(err), 0);
        check({tag, "_err_count"}, int'(err_count), 0);
    endtask

    vec_t tbl[15];

    initial begin
        int err0;
        int rxv0;
        int start;

        // lines, bad_line, xpat, lk_during | locked, err_count, err pulses, frame_done, sum, rx_valid count
        tbl[0]  = '{9, -1, 1'b0, 1'b0, 1'b0, 0, 0, 0, 0,       0};
        tbl[1]  = '{9, -1, 1'b0, 1'b0, 1'b0, 0, 0, 0, 0,       0};
        tbl[2]  = '{9, -1, 1'b1, 1'b1, 1'b1, 0, 0, 1, SUM_ONE, SUM_ONE};
        tbl[3]  = '{9, -1, 1'b0, 1'b1, 1'b1, 0, 0, 1, SUM_X,   SUM_ONE};
        tbl[4]  = '{9,  5, 1'b0, 1'b1, 1'b0, 1, 1, 1, SUM_ONE, 3 * H_ACTIVE};
        tbl[5]  = '{9, -1, 1'b0, 1'b0, 1'b0, 1, 0, 0, 0,       0};
        tbl[6]  = '{9, -1, 1'b0, 1'b0, 1'b0, 1, 0, 0, 0,       0};
        tbl[7]  = '{9, -1, 1'b0, 1'b1, 1'b1, 1, 0, 1, SUM_ONE, SUM_ONE};
        tbl[8]  = '{8, -1, 1'b1, 1'b1, 1'b1, 1, 0, 1, SUM_ONE, SUM_ONE};
        tbl[9]  = '{9, -1, 1'b0, 1'b0, 1'b0, 2, 1, 0, 0,       0};
        tbl[10] = '{9, -1, 1'b0, 1'b0, 1'b0, 2, 0, 0, 0,       0};
        tbl[11] = '{8, -1, 1'b0, 1'b0, 1'b0, 2, 0, 0, 0,       0};
        tbl[12] = '{9, -1, 1'b0, 1'b0, 1'b0, 2, 0, 0, 0,       0};
        tbl[13] = '{9, -1, 1'b0, 1'b0, 1'b0, 2, 0, 0, 0,       0};
        tbl[14] = '{9, -1, 1'b0, 1'b1, 1'b1, 2, 0, 1, SUM_ONE, SUM_ONE};

        reset  = 1'b1;
        pix_en = 1'b0;
        hsync  = 1'b1;
        vsync  = 1'b1;
        rgb    = '0;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        reset = 1'b0;

        for (int i = 0; i < 15; i++) apply_row(i, tbl[i]);

        // Both syncs stuck inactive while locked: one loss of lock when h saturates, then silence.
        err0  = n_err;
        start = tick_no;
        repeat (1100) tick(1'b1, 1'b1, 12'hFFF);
        check("stuck_err_pulses", n_err - err0, 1);
        check("stuck_err_tick", err_at - start, 1023 - (H_TOTAL - 1));
        check("stuck_locked", int'(locked), 0);
        check("stuck_err_count", int'(err_count), 3);

        apply_row(15, '{9, -1, 1'b0, 1'b0, 1'b0, 3, 0, 0, 0, 0});
        apply_row(16, '{9, -1, 1'b0, 1'b0, 1'b0, 3, 0, 0, 0, 0});
        apply_row(17, '{9, -1, 1'b0, 1'b1, 1'b1, 3, 0, 1, SUM_ONE, SUM_ONE});

        // Reset in the middle of a locked frame clears everything without an err pulse.
        rxv0 = n_rxv;
        send_frame(5, -1, 1'b1, 1'b1);
        check("midrst_pre_rx_valid_count", n_rxv - rxv0, 2 * H_ACTIVE);
        check("midrst_pre_locked", int'(locked), 1);
        check("midrst_pre_err_count", int'(err_count), 3);
        err0   = n_err;
        exp_lk = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check_all_zero("midrst");
        repeat (8) @(negedge clk);
        check("midrst_err_pulses", n_err - err0, 0);
        check("midrst_err_count_hold", int'(err_count), 0);

        check("sb_leftover", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
